// File: rtl/pre_cal_pkg.sv
// Shared types and FSM encoding for the LMMSE pre-calculation scheduler.
package pre_cal_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef logic [3:0][3:0][DATA_W_DEFAULT-1:0] mat4_t;
  typedef logic [3:0][DATA_W_DEFAULT-1:0]      vec4_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRAM_REQ  = 3'd1,
    GRAM_WAIT = 3'd2,
    MF_REQ    = 3'd3,
    MF_WAIT   = 3'd4,
    OUT       = 3'd5
  } state_e;

endpackage

// File: rtl/pre_cal_sched.sv
// Sequences an external 4x4 matmul to build A = H^T*H + snr*I and b = H^T*r
// for one job at a time, with a bounded wait on each matmul result.
module pre_cal_sched
  import pre_cal_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int MM_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0][3:0][DATA_W-1:0] in_H,
  input  logic [3:0][DATA_W-1:0]      in_r,
  input  logic [DATA_W-1:0]           in_snr,
  input  logic [7:0]                  in_tag,
  output logic                        mm_req_valid,
  input  logic                        mm_req_ready,
  output logic [3:0][3:0][DATA_W-1:0] mm_a,
  output logic [3:0][3:0][DATA_W-1:0] mm_b,
  input  logic                        mm_res_valid,
  input  logic [3:0][3:0][DATA_W-1:0] mm_res,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0][3:0][DATA_W-1:0] out_A,
  output logic [3:0][DATA_W-1:0]      out_b,
  output logic [7:0]                  out_tag,
  output logic                        busy,
  output logic                        err_timeout,
  output logic [15:0]                 job_count
);

  localparam int               CNT_W    = $clog2(MM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_TIMEOUT - 1);

  state_e                      r_state, w_next;
  logic [CNT_W-1:0]            r_wait_cnt;
  logic [3:0][3:0][DATA_W-1:0] r_H, r_A, w_ht, w_mf_b;
  logic [3:0][DATA_W-1:0]      r_r, r_b;
  logic [DATA_W-1:0]           r_snr;
  logic [7:0]                  r_tag;
  logic                        r_in_ready, r_mm_req_valid, r_out_valid, r_busy, r_err_timeout;
  logic [15:0]                 r_job_count;
  logic                        w_in_fire, w_req_fire, w_out_fire, w_in_wait, w_timeout;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_req_fire = r_mm_req_valid & mm_req_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_in_wait  = (r_state == GRAM_WAIT) || (r_state == MF_WAIT);
  assign w_timeout  = w_in_wait && !mm_res_valid && (r_wait_cnt == CNT_LAST);

  // Operand shaping: transpose of H, and r placed in the first group of mm_b
  always_comb begin
    w_ht   = '0;
    w_mf_b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_ht[i][j] = r_H[j][i];
      end
    end
    w_mf_b[0] = r_r;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_in_fire) w_next = GRAM_REQ; else w_next = IDLE;
      GRAM_REQ:  if (w_req_fire) w_next = GRAM_WAIT; else w_next = GRAM_REQ;
      GRAM_WAIT: if (mm_res_valid) w_next = MF_REQ;
                 else if (w_timeout) w_next = IDLE;
                 else w_next = GRAM_WAIT;
      MF_REQ:    if (w_req_fire) w_next = MF_WAIT; else w_next = MF_REQ;
      MF_WAIT:   if (mm_res_valid) w_next = OUT;
                 else if (w_timeout) w_next = IDLE;
                 else w_next = MF_WAIT;
      OUT:       if (w_out_fire) w_next = IDLE; else w_next = OUT;
      default:   w_next = IDLE;
    endcase
  end

  // State register and wait counter; the counter restarts on every WAIT entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_in_wait && (w_next == r_state)) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else                                  r_wait_cnt <= '0;
    end
  end

  // Job capture and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_H   <= '0;
      r_r   <= '0;
      r_snr <= '0;
      r_tag <= '0;
      r_A   <= '0;
      r_b   <= '0;
    end else begin
      if (w_in_fire) begin
        r_H   <= in_H;
        r_r   <= in_r;
        r_snr <= in_snr;
        r_tag <= in_tag;
      end
      if ((r_state == GRAM_WAIT) && mm_res_valid) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            r_A[i][j] <= mm_res[i][j] + ((i == j) ? r_snr : {DATA_W{1'b0}});
          end
        end
      end
      if ((r_state == MF_WAIT) && mm_res_valid) begin
        for (int i = 0; i < 4; i++) r_b[i] <= mm_res[0][i];
      end
    end
  end

  // Handshake/status outputs, registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready     <= 1'b0;
      r_mm_req_valid <= 1'b0;
      r_out_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_job_count    <= 16'd0;
    end else begin
      r_in_ready     <= (w_next == IDLE);
      r_mm_req_valid <= (w_next == GRAM_REQ) || (w_next == MF_REQ);
      r_out_valid    <= (w_next == OUT);
      r_busy         <= (w_next != IDLE);
      if (w_timeout) r_err_timeout <= 1'b1;
      if ((r_state == OUT) && w_out_fire) r_job_count <= r_job_count + 16'd1;
    end
  end

  assign in_ready     = r_in_ready;
  assign mm_req_valid = r_mm_req_valid;
  assign mm_a         = w_ht;
  assign mm_b         = (r_state == MF_REQ) ? w_mf_b : r_H;
  assign out_valid    = r_out_valid;
  assign out_A        = r_A;
  assign out_b        = r_b;
  assign out_tag      = r_tag;
  assign busy         = r_busy;
  assign err_timeout  = r_err_timeout;
  assign job_count    = r_job_count;

endmodule

// File: doc/pre_cal_sched.md
PRE_CAL_SCHED -- requirements
Module: pre_cal_sched

Interface
REQ-001 parameter DATA_W, 32, signed sample width.
REQ-002 parameter MM_TIMEOUT, 64, max cycles to wait for a matmul result.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  job offered.
REQ-006 in_ready  output  1  job accepted when in_valid && in_ready.
REQ-007 in_H  input  [4][4]xDATA_W  channel matrix H.
REQ-008 in_r  input  [4]xDATA_W  received vector r.
REQ-009 in_snr  input  DATA_W  diagonal regulariser.
REQ-010 in_tag  input  8  subcarrier index.
REQ-011 mm_req_valid  output  1  matmul operands valid.
REQ-012 mm_req_ready  input  1  matmul accepts operands.
REQ-013 mm_a, mm_b  output  [4][4]xDATA_W  matmul operands.
REQ-014 mm_res_valid  input  1  matmul result valid.
REQ-015 mm_res  input  [4][4]xDATA_W  matmul result.
REQ-016 out_valid / out_ready  output / input  1  result handshake.
REQ-017 out_A  output  [4][4]xDATA_W  A = H^T*H + snr*I.
REQ-018 out_b  output  [4]xDATA_W  b = H^T*r.
REQ-019 out_tag  output  8  tag of the job.
REQ-020 busy  output  1  state != IDLE.
REQ-021 err_timeout  output  1  sticky matmul-timeout flag.
REQ-022 job_count  output  16  completed-job count.

Function
REQ-023 FSM states: IDLE, GRAM_REQ, GRAM_WAIT, MF_REQ, MF_WAIT, OUT.
REQ-024 in_ready = 1 only in IDLE; handshake registers H, r, snr, tag; IDLE->GRAM_REQ.
REQ-025 GRAM_REQ: mm_a = H^T, mm_b = H; mm_req_valid held with stable operands until mm_req_ready, then ->GRAM_WAIT.
REQ-026 GRAM_WAIT: on mm_res_valid register A[i][j] = mm_res[i][j] (+snr when i==j), two's-complement wrap at DATA_W; ->MF_REQ.
REQ-027 MF_REQ: mm_a = H^T, mm_b row 0 = r, rows 1-3 = 0; handshake as GRAM_REQ; ->MF_WAIT.
REQ-028 MF_WAIT: on mm_res_valid register b[i] = mm_res[0][i]; ->OUT.
REQ-029 mm_res_valid outside the WAIT states is ignored.
REQ-030 OUT: out_valid = 1, out_A/out_b/out_tag stable until out_ready; on handshake job_count += 1 (0xFFFF wraps to 0), ->IDLE.
REQ-031 out_valid rises the cycle after mm_res_valid is sampled in MF_WAIT; in_ready re-asserts the cycle after the out handshake (one-cycle bubble).
REQ-032 A wait counter clears on entering either WAIT state; if it reaches MM_TIMEOUT without mm_res_valid: err_timeout <= 1, job dropped (no out_valid), ->IDLE.
REQ-033 err_timeout is cleared only by reset; it does not block later jobs.
REQ-034 mm_req_valid = 0 in all states except GRAM_REQ and MF_REQ.

Reset
REQ-035 reset_n low: state IDLE, all outputs 0 (in_ready=0 while asserted, 1 the first cycle after release), counters and data registers 0.
REQ-036 Reset mid-job aborts it; no out_valid and no job_count change for that job.

Structure
REQ-037 Package pre_cal_pkg holds DATA_W default, mat4_t/vec4_t types, and the FSM state enum.
REQ-038 No sub-module; the matmul instance stays outside, connected through the mm_* ports.

Verification
REQ-039 H=I, r=[1,2,3,4], snr=5, immediate matmul model -> out_A = diag(6), off-diagonals 0, out_b=[1,2,3,4], job_count=1.
REQ-040 H all 2, r all 1, snr=3 -> out_A diagonal 19, off-diagonals 16, out_b all 8.
REQ-041 out_ready low for 10 cycles -> out_valid and data held, in_ready=0 throughout, exactly one job_count increment.
REQ-042 matmul never returns mm_res_valid -> err_timeout=1 after 64 WAIT cycles, no out_valid, in_ready=1 next cycle, next job completes normally.
REQ-043 gram diagonal 1, snr=0x7FFFFFFF -> out_A diagonal 0x80000000.
REQ-044 reset_n pulsed low in MF_WAIT -> all outputs 0, no output for that job, job_count unchanged.
